// File: rtl/uart_pkg.sv
// Shared definitions for the UART command front end.
//   SYNC_BYTE_DEF : default frame start marker
//   OP_W          : opcode width presented to the ALU
//   state_t       : command parser state encoding
package uart_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         OP_W          = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC,
    ST_OPA,
    ST_OPB,
    ST_CHK,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/uart_cmd_frontend_byte_fifo.sv
// Synchronous byte FIFO between the UART receiver and the command parser.
//   clk, reset : clock, asynchronous active-low reset (pointers/count only)
//   wr, din    : write strobe and byte; ignored when full unless rd also pops
//   rd         : pop the head byte; ignored when empty
//   dout       : head byte, shown combinationally
//   full/empty : occupancy flags
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_wr;
  logic          do_rd;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign dout  = mem[rp];

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a
  // byte when it is popped simultaneously.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_wr) wp <= wp + AW'(1);
      if (do_rd) rp <= rp + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= din;
  end

endmodule

// File: rtl/uart_cmd_frontend.sv
// UART command front end: buffers received bytes and parses frames
//   SYNC, OPCODE, A[NB bytes, LSB first], B[NB bytes, LSB first], CHECKSUM
// where CHECKSUM is the XOR of opcode and operand bytes (sync excluded).
//   clk, reset            : clock, asynchronous active-low reset
//   rx_done_tick, rx_dout : byte strobe and byte from the UART receiver
//   op, a, b, cmd_valid   : validated command, held until cmd_ready
//   cmd_ready             : consumer accepts on cmd_valid && cmd_ready
//   err_chk/timeout/overflow : one-cycle error pulses
//   busy                  : parser is not in IDLE
module uart_cmd_frontend
  import uart_pkg::*;
#(
  parameter int         DATA_W      = 8,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_done_tick,
  input  logic [7:0]               rx_dout,
  output logic signed [DATA_W-1:0] a,
  output logic signed [DATA_W-1:0] b,
  output logic [OP_W-1:0]          op,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic                     err_chk,
  output logic                     err_timeout,
  output logic                     err_overflow,
  output logic                     busy
);

  localparam int NB  = DATA_W / 8;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TCW-1:0] TMAX      = TCW'(TIMEOUT_CYC);
  localparam logic [BCW-1:0] BCNT_LAST = BCW'(NB - 1);

  state_t         state;
  state_t         state_n;
  logic [7:0]     rbyte;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;
  logic           ovf;
  logic           tmo;
  logic           chk_bad;
  logic           in_frame;
  logic           bcnt_last;
  logic [7:0]     chk;
  logic [BCW-1:0] bcnt;
  logic [TCW-1:0] tcnt;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (rx_done_tick),
    .rd    (pop),
    .din   (rx_dout),
    .dout  (rbyte),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pop       = !fifo_empty && (state != ST_HOLD);
  assign ovf       = rx_done_tick && fifo_full && !pop;
  assign in_frame  = (state == ST_OPC) || (state == ST_OPA) ||
                     (state == ST_OPB) || (state == ST_CHK);
  assign bcnt_last = (bcnt == BCNT_LAST);
  assign busy      = (state != ST_IDLE);

  // A byte popped in the same cycle the counter expires wins over the timeout.
  assign tmo = in_frame && !pop && (TIMEOUT_CYC != 0) && (tcnt == TMAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    chk_bad = 1'b0;
    if (tmo) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (pop && rbyte == SYNC_BYTE) state_n = ST_OPC;
        ST_OPC:  if (pop) state_n = ST_OPA;
        ST_OPA:  if (pop && bcnt_last) state_n = ST_OPB;
        ST_OPB:  if (pop && bcnt_last) state_n = ST_CHK;
        ST_CHK: begin
          if (pop) begin
            if (rbyte == chk) begin
              state_n = ST_HOLD;
            end else begin
              state_n = ST_IDLE;
              chk_bad = 1'b1;
            end
          end
        end
        ST_HOLD: if (cmd_valid && cmd_ready) state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op           <= '0;
      a            <= '0;
      b            <= '0;
      chk          <= '0;
      bcnt         <= '0;
      tcnt         <= '0;
      cmd_valid    <= 1'b0;
      err_chk      <= 1'b0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_chk      <= chk_bad;
      err_timeout  <= tmo;
      err_overflow <= ovf;

      // Inter-byte idle counter; saturates so a disabled timeout never wraps.
      if (!in_frame || pop)  tcnt <= '0;
      else if (tcnt != TMAX) tcnt <= tcnt + TCW'(1);

      if (pop) begin
        case (state)
          ST_IDLE: if (rbyte == SYNC_BYTE) chk <= '0;
          ST_OPC: begin
            op   <= rbyte[OP_W-1:0];
            chk  <= chk ^ rbyte;
            bcnt <= '0;
          end
          ST_OPA: begin
            a[8*int'(bcnt) +: 8] <= rbyte;
            chk  <= chk ^ rbyte;
            bcnt <= bcnt_last ? '0 : bcnt + BCW'(1);
          end
          ST_OPB: begin
            b[8*int'(bcnt) +: 8] <= rbyte;
            chk  <= chk ^ rbyte;
            bcnt <= bcnt_last ? '0 : bcnt + BCW'(1);
          end
          default: ;
        endcase
      end

      // cmd_valid rises one edge after entering HOLD and drops on acceptance.
      if (state == ST_HOLD) begin
        if (!cmd_valid)     cmd_valid <= 1'b1;
        else if (cmd_ready) cmd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_frontend.sv
module tb_uart_cmd_frontend;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 8-bit operand instance with a short timeout
  logic              tick8, rdy8;
  logic [7:0]        dout8;
  logic signed [7:0] a8, b8;
  logic [5:0]        op8;
  logic              vld8, echk8, etmo8, eovf8, busy8;

  // 16-bit operand instance with default timeout
  logic               tick16, rdy16;
  logic [7:0]         dout16;
  logic signed [15:0] a16, b16;
  logic [5:0]         op16;
  logic               vld16, echk16, etmo16, eovf16, busy16;

  uart_cmd_frontend #(.DATA_W(8), .FIFO_DEPTH(4), .TIMEOUT_CYC(50)) dut8 (
    .clk(clk), .reset(reset), .rx_done_tick(tick8), .rx_dout(dout8),
    .a(a8), .b(b8), .op(op8), .cmd_valid(vld8), .cmd_ready(rdy8),
    .err_chk(echk8), .err_timeout(etmo8), .err_overflow(eovf8), .busy(busy8)
  );

  uart_cmd_frontend #(.DATA_W(16)) dut16 (
    .clk(clk), .reset(reset), .rx_done_tick(tick16), .rx_dout(dout16),
    .a(a16), .b(b16), .op(op16), .cmd_valid(vld16), .cmd_ready(rdy16),
    .err_chk(echk16), .err_timeout(etmo16), .err_overflow(eovf16), .busy(busy16)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_echk8 = 0, n_etmo8 = 0, n_eovf8 = 0, n_vld8 = 0;
  int c_chk, c_tmo, c_ovf, c_vld;

  always @(negedge clk) begin
    if (echk8) n_echk8++;
    if (etmo8) n_etmo8++;
    if (eovf8) n_eovf8++;
    if (vld8)  n_vld8++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send8(input logic [7:0] v);
    @(negedge clk);
    tick8 = 1'b1;
    dout8 = v;
    @(negedge clk);
    tick8 = 1'b0;
  endtask

  task automatic send16(input logic [7:0] v);
    @(negedge clk);
    tick16 = 1'b1;
    dout16 = v;
    @(negedge clk);
    tick16 = 1'b0;
  endtask

  task automatic wait_vld8(input string tag);
    int i = 0;
    while (!vld8 && i < 20) begin
      @(negedge clk);
      i++;
    end
    check(tag, {31'd0, vld8}, 32'd1);
  endtask

  task automatic accept8(input string tag);
    rdy8 = 1'b1;
    @(negedge clk);
    rdy8 = 1'b0;
    check(tag, {30'd0, vld8, busy8}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    tick8 = 1'b0; dout8 = '0; rdy8 = 1'b0;
    tick16 = 1'b0; dout16 = '0; rdy16 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_vld",  {31'd0, vld8}, 32'd0);
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_op",   op8, 32'd0);
    check("rst_ab",   {a8, b8}, 32'd0);
    check("rst_err",  {echk8, etmo8, eovf8}, 32'd0);
    check("rst_e16",  {vld16, busy16, echk16, etmo16, eovf16}, 32'd0);

    // Basic 8-bit frame with latency check
    send8(8'hA5); send8(8'h01); send8(8'h05); send8(8'h03); send8(8'h07);
    @(negedge clk);
    check("lat_e1", {31'd0, vld8}, 32'd0);
    @(negedge clk);
    check("lat_e2", {31'd0, vld8}, 32'd1);
    check("f1_op", op8, 32'd1);
    check("f1_a",  a8, 32'd5);
    check("f1_b",  b8, 32'd3);
    check("f1_busy", {31'd0, busy8}, 32'd1);
    accept8("f1_acc");

    // 16-bit operands, little-endian
    send16(8'hA5); send16(8'h02); send16(8'h34); send16(8'h12);
    send16(8'h02); send16(8'h00); send16(8'h26);
    begin
      int i = 0;
      while (!vld16 && i < 20) begin
        @(negedge clk);
        i++;
      end
    end
    check("w16_vld", {31'd0, vld16}, 32'd1);
    check("w16_op",  op16, 32'd2);
    check("w16_a",   {16'd0, a16}, 32'h1234);
    check("w16_b",   {16'd0, b16}, 32'h0002);
    rdy16 = 1'b1;
    @(negedge clk);
    rdy16 = 1'b0;
    check("w16_acc", {30'd0, vld16, busy16}, 32'd0);

    // Leading garbage and a bad checksum
    c_chk = n_echk8; c_vld = n_vld8;
    send8(8'h00); send8(8'hFF); send8(8'hA5); send8(8'h01);
    send8(8'h05); send8(8'h03); send8(8'h08);
    repeat (4) @(negedge clk);
    check("bad_chk_cnt", n_echk8 - c_chk, 32'd1);
    check("bad_no_vld",  n_vld8 - c_vld, 32'd0);
    check("bad_idle",    {31'd0, busy8}, 32'd0);

    // Timeout inside a frame, then recovery
    c_tmo = n_etmo8;
    send8(8'hA5); send8(8'h01);
    repeat (60) @(negedge clk);
    check("tmo_cnt",  n_etmo8 - c_tmo, 32'd1);
    check("tmo_idle", {31'd0, busy8}, 32'd0);
    send8(8'hA5); send8(8'h01); send8(8'h05); send8(8'h03); send8(8'h07);
    wait_vld8("tmo_rec_vld");
    check("tmo_rec_cmd", {op8, a8, b8}, {8'd0, 2'b00, 6'd1, 8'd5, 8'd3});
    accept8("tmo_rec_acc");
    check("tmo_once", n_etmo8 - c_tmo, 32'd1);

    // Overflow while holding a command
    c_ovf = n_eovf8; c_chk = n_echk8;
    send8(8'hA5); send8(8'h01); send8(8'h05); send8(8'h03); send8(8'h07);
    wait_vld8("ovf_vld1");
    send8(8'hA5); send8(8'h02); send8(8'h07); send8(8'h01); send8(8'h04); send8(8'h99);
    @(negedge clk);
    check("ovf_cnt",  n_eovf8 - c_ovf, 32'd2);
    check("ovf_full", {31'd0, dut8.u_fifo.full}, 32'd1);
    check("ovf_hold", {vld8, 1'b0, op8}, {24'd0, 1'b1, 1'b0, 6'd1});
    accept8("ovf_acc1");
    repeat (6) @(negedge clk);
    check("ovf_wait_chk", {31'd0, busy8}, 32'd1);
    send8(8'h04);
    wait_vld8("ovf_vld2");
    check("ovf_cmd2", {op8, a8, b8}, {8'd0, 2'b00, 6'd2, 8'd7, 8'd1});
    check("ovf_nochk", n_echk8 - c_chk, 32'd0);
    accept8("ovf_acc2");

    // Reset mid-frame
    send8(8'hA5); send8(8'h01); send8(8'h05);
    reset = 1'b0;
    #1;
    check("mrst_out",   {op8, a8, b8}, 32'd0);
    check("mrst_ctl",   {vld8, busy8, echk8, etmo8, eovf8}, 32'd0);
    check("mrst_empty", {31'd0, dut8.u_fifo.empty}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    send8(8'hA5); send8(8'h03); send8(8'hFE); send8(8'h02); send8(8'hFF);
    wait_vld8("neg_vld");
    check("neg_op", op8, 32'd3);
    check("neg_a",  a8, -2);
    check("neg_b",  b8, 32'd2);
    accept8("neg_acc");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_cmd_frontend.md
Name: uart_cmd_frontend

Overview:
Parametrised successor to the byte-level rx interface. It receives UART bytes, buffers them in a small FIFO, and parses framed commands: sync byte, opcode, operand A, operand B and an XOR checksum. Operands are DATA_W wide. It presents a validated {op, a, b} to the ALU through a valid/ready handshake and reports checksum, timeout and overflow errors. It sits between the UART rx module and the ALU.

Parameters:
DATA_W, 8, operand width in bits; must be a multiple of 8 (8/16/32); NB = DATA_W/8 bytes per operand.
FIFO_DEPTH, 4, rx byte buffer depth; power of two, at least 2.
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CYC, 1000, idle clocks allowed between bytes inside a frame; 0 disables the timeout.

Ports:
clk  in  1  system clock; the only clock.
reset  in  1  asynchronous, active-low reset.
rx_done_tick  in  1  one-cycle strobe: rx_dout holds a new byte.
rx_dout  in  8  received byte.
a  out  DATA_W  operand A, signed, little-endian assembled.
b  out  DATA_W  operand B, signed, little-endian assembled.
op  out  6  opcode, taken from bits [5:0] of the opcode byte.
cmd_valid  out  1  {op,a,b} is valid; held until accepted.
cmd_ready  in  1  consumer accepts the command when cmd_valid && cmd_ready.
err_chk  out  1  one-cycle pulse: checksum mismatch.
err_timeout  out  1  one-cycle pulse: frame abandoned on timeout.
err_overflow  out  1  one-cycle pulse: byte dropped because the FIFO was full.
busy  out  1  parser is in a state other than IDLE.

Behaviour:
- Reset (asynchronous, active-low): FIFO empty; state IDLE; a, b and op are 0; cmd_valid, busy and all err_* are 0; checksum and counters are 0.
- FIFO write: occurs on rx_done_tick when the FIFO is not full. If the FIFO is full, the byte is dropped and err_overflow pulses on the next cycle.
- FIFO pop: the parser pops one byte per cycle while the FIFO is non-empty and state != HOLD.
- Parser states:
  - IDLE: pop a byte. If it equals SYNC_BYTE, go to OPC and clear chk. Any other byte is discarded (hunt mode).
  - OPC: op <= byte[5:0]; chk ^= byte; go to OPA with bcnt=0.
  - OPA: a[8*bcnt +: 8] <= byte; chk ^= byte. After NB bytes, go to OPB with bcnt=0.
  - OPB: same as OPA for b. After NB bytes, go to CHK.
  - CHK: if byte == chk, go to HOLD and set cmd_valid on the next edge. Otherwise pulse err_chk and go to IDLE; a/b/op keep stale values and cmd_valid stays 0.
  - HOLD: cmd_valid=1 and a/b/op are stable. On cmd_valid && cmd_ready, cmd_valid drops on the next edge and the parser returns to IDLE. No pops occur in HOLD; incoming bytes accumulate in the FIFO.
- Latency: with the FIFO empty and the parser free, cmd_valid rises on the 2nd rising edge after the edge that samples the checksum byte's rx_done_tick (1 cycle to write the FIFO, 1 cycle to pop and check).
- Sync byte inside a frame: treated as data, not as a resync.
- Timeout: a counter clears on every pop. In OPC, OPA, OPB or CHK, if it reaches TIMEOUT_CYC, pulse err_timeout and go to IDLE. The counter is held at 0 in IDLE and HOLD.
- Simultaneous FIFO write and pop: both succeed, including when the FIFO is full (count stays full, no overflow).
- Reset asserted mid-frame: immediate return to the reset state; the partial frame and all FIFO contents are lost.
- Checksum: XOR of the opcode byte and all operand bytes; the sync byte is excluded.

Decomposition:
- Shared package uart_pkg: SYNC_BYTE default, parser state encoding (IDLE, OPC, OPA, OPB, CHK, HOLD), OP_W=6.
- One sub-module, byte_fifo, a synchronous FIFO with parameter DEPTH and width 8. Ports: clk, reset, wr, rd, din, dout, full, empty. dout shows the head combinationally.

Test Plan:
- DATA_W=8, bytes A5 01 05 03 07 -> cmd_valid with op=1, a=5, b=3; accept with cmd_ready=1 -> cmd_valid=0 next cycle; busy=0.
- DATA_W=16, bytes A5 02 34 12 02 00 26 -> op=2, a=16'h1234, b=16'h0002.
- DATA_W=8, bytes 00 FF A5 01 05 03 08 -> leading garbage discarded; err_chk pulses once; no cmd_valid; parser back in IDLE.
- TIMEOUT_CYC=50, bytes A5 01, then silence for 60 cycles -> err_timeout pulses exactly once; a following good frame A5 01 05 03 07 is then accepted.
- FIFO_DEPTH=4, cmd_ready=0, a valid frame followed by 6 bytes of a second frame -> 4 bytes buffered, err_overflow pulses twice. After cmd_ready=1 the first command is accepted and the remaining bytes are parsed.
- Assert reset for one cycle after A5 01 05 -> all outputs 0 and FIFO empty; then A5 03 FE 02 FF -> op=3, a=-2, b=2.
